sch_pipe: RTL and testbench

Pipelined, parametrised successor to the bit-slice add-then-multiply chain.
- Ripple-adds two N-bit operands plus a carry-in. Each sum bit becomes the MSB of a 2-bit multiplicand {sum[i], m2[i]}, which is multiplied by the 2-bit multiplier {m1[i], m0[i]}.
- Each lane's 4-bit product is scattered across mout3..mout0 at bit i.
- Adds a valid/ready handshake, two register stages with back-pressure, and a carry-chaining mode for multi-word operation.

---
 rtl/sch_pkg.sv | 18 +
 rtl/sch_lane_mul.sv | 13 +
 rtl/sch_pipe.sv | 126 ++++++++++++
 tb/tb_sch_pipe.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/sch_pkg.sv
// sch_pipe shared types and helpers.
// Lane product width and 2x2 multiply, also used by reference models.
package sch_pkg;

  localparam int PROD_W = 4;

  function automatic logic [PROD_W-1:0] mul2x2(
    input logic [1:0] a,
    input logic [1:0] b
  );
    logic [PROD_W-1:0] ax;
    logic [PROD_W-1:0] bx;
    ax = {2'b00, a};
    bx = {2'b00, b};
    return ax * bx;
  endfunction

endpackage

// File: rtl/sch_lane_mul.sv
// One lane of the sch_pipe multiply stage.
// Combinational 2-bit by 2-bit multiply, 4-bit result.
module sch_lane_mul
  import sch_pkg::*;
(
  input  logic [1:0]        a,
  input  logic [1:0]        b,
  output logic [PROD_W-1:0] p
);

  assign p = mul2x2(a, b);

endmodule

// File: rtl/sch_pipe.sv
// Two-stage add-then-multiply lane array with valid/ready flow control.
// Ripple add in stage 1, per-lane 2x2 multiply registered in stage 2.
module sch_pipe
  import sch_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a1,
  input  logic [N-1:0] a0,
  input  logic         cin,
  input  logic         chain,
  input  logic [N-1:0] m2,
  input  logic [N-1:0] m1,
  input  logic [N-1:0] m0,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] mout3,
  output logic [N-1:0] mout2,
  output logic [N-1:0] mout1,
  output logic [N-1:0] mout0,
  output logic         cout
);

  logic         s1_v;
  logic         s2_v;
  logic         carry_q;
  logic [N-1:0] s1_sum;
  logic [N-1:0] s1_m2;
  logic [N-1:0] s1_m1;
  logic [N-1:0] s1_m0;
  logic         s1_c;
  logic [N-1:0] s2_p3;
  logic [N-1:0] s2_p2;
  logic [N-1:0] s2_p1;
  logic [N-1:0] s2_p0;
  logic         s2_c;

  logic         s2_ld;
  logic         s1_ld;
  logic         acc;
  logic [N:0]   c;
  logic [N-1:0] sum;
  logic [PROD_W-1:0] prod [N];

  assign s2_ld    = !s2_v || out_ready;
  assign s1_ld    = !s1_v || s2_ld;
  assign in_ready = s1_ld;
  assign acc      = in_valid && in_ready;

  always_comb begin
    c   = '0;
    sum = '0;
    c[0] = chain ? carry_q : cin;
    for (int i = 0; i < N; i++) begin
      sum[i]   = a0[i] ^ a1[i] ^ c[i];
      c[i+1]   = (a0[i] & a1[i]) |
                 (a0[i] & c[i])  |
                 (a1[i] & c[i]);
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    sch_lane_mul u_mul (
      .a ({s1_sum[i], s1_m2[i]}),
      .b ({s1_m1[i], s1_m0[i]}),
      .p (prod[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v    <= 1'b0;
      carry_q <= 1'b0;
      s1_sum  <= '0;
      s1_m2   <= '0;
      s1_m1   <= '0;
      s1_m0   <= '0;
      s1_c    <= 1'b0;
    end else if (s1_ld) begin
      s1_v <= acc;
      if (acc) begin
        carry_q <= c[N];
        s1_sum  <= sum;
        s1_m2   <= m2;
        s1_m1   <= m1;
        s1_m0   <= m0;
        s1_c    <= c[N];
      end
    end
  end

  // Data only moves with a real transaction so idle outputs stay put.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v  <= 1'b0;
      s2_p3 <= '0;
      s2_p2 <= '0;
      s2_p1 <= '0;
      s2_p0 <= '0;
      s2_c  <= 1'b0;
    end else if (s2_ld) begin
      s2_v <= s1_v;
      if (s1_v) begin
        for (int i = 0; i < N; i++) begin
          s2_p3[i] <= prod[i][3];
          s2_p2[i] <= prod[i][2];
          s2_p1[i] <= prod[i][1];
          s2_p0[i] <= prod[i][0];
        end
        s2_c <= s1_c;
      end
    end
  end

  assign out_valid = s2_v;
  assign mout3     = s2_p3;
  assign mout2     = s2_p2;
  assign mout1     = s2_p1;
  assign mout0     = s2_p0;
  assign cout      = s2_c;

endmodule

// File: tb/tb_sch_pipe.sv
// Directed vector bench for sch_pipe (N=4).
// Table of transactions plus back-pressure and reset sequences.
module tb_sch_pipe;

  localparam int N = 4;

  typedef struct {
    logic       chain;
    logic       cin;
    logic [3:0] a0;
    logic [3:0] a1;
    logic [3:0] m2;
    logic [3:0] m1;
    logic [3:0] m0;
    logic [3:0] e3;
    logic [3:0] e2;
    logic [3:0] e1;
    logic [3:0] e0;
    logic       ec;
  } vec_t;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a1;
  logic [N-1:0] a0;
  logic         cin;
  logic         chain;
  logic [N-1:0] m2;
  logic [N-1:0] m1;
  logic [N-1:0] m0;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] mout3;
  logic [N-1:0] mout2;
  logic [N-1:0] mout1;
  logic [N-1:0] mout0;
  logic         cout;

  int n_cmp;
  int n_err;

  vec_t tv [7];

  sch_pipe #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a1        (a1),
    .a0        (a0),
    .cin       (cin),
    .chain     (chain),
    .m2        (m2),
    .m1        (m1),
    .m0        (m0),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .mout3     (mout3),
    .mout2     (mout2),
    .mout1     (mout1),
    .mout0     (mout0),
    .cout      (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    chain = v.chain;
    cin   = v.cin;
    a0    = v.a0;
    a1    = v.a1;
    m2    = v.m2;
    m1    = v.m1;
    m0    = v.m0;
  endtask

  task automatic chk_out(input string name, input vec_t v);
    chk({name, ".valid"}, {31'd0, out_valid}, 32'd1);
    chk({name, ".mout3"}, {28'd0, mout3}, {28'd0, v.e3});
    chk({name, ".mout2"}, {28'd0, mout2}, {28'd0, v.e2});
    chk({name, ".mout1"}, {28'd0, mout1}, {28'd0, v.e1});
    chk({name, ".mout0"}, {28'd0, mout0}, {28'd0, v.e0});
    chk({name, ".cout"},  {31'd0, cout},  {31'd0, v.ec});
  endtask

  task automatic chk_idle(input string name);
    chk({name, ".valid"}, {31'd0, out_valid}, 32'd0);
    chk({name, ".ready"}, {31'd0, in_ready},  32'd1);
    chk({name, ".mout"},
        {16'd0, mout3, mout2, mout1, mout0}, 32'd0);
    chk({name, ".cout"}, {31'd0, cout}, 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    // chain cin a0 a1 m2 m1 m0 | e3 e2 e1 e0 cout
    tv[0] = '{0, 0, 4'h3, 4'h1, 4'hF, 4'h0, 4'hF,
              4'h0, 4'h0, 4'h4, 4'hF, 0};
    tv[1] = '{0, 0, 4'hF, 4'h0, 4'hF, 4'hF, 4'hF,
              4'hF, 4'h0, 4'h0, 4'hF, 0};
    tv[2] = '{0, 1, 4'hF, 4'h0, 4'h0, 4'h0, 4'hF,
              4'h0, 4'h0, 4'h0, 4'h0, 1};
    tv[3] = '{0, 0, 4'hF, 4'h1, 4'h0, 4'h0, 4'hF,
              4'h0, 4'h0, 4'h0, 4'h0, 1};
    tv[4] = '{1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF,
              4'h0, 4'h0, 4'h1, 4'h0, 0};
    tv[5] = tv[3];
    tv[6] = '{0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF,
              4'h0, 4'h0, 4'h0, 4'h0, 0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drive(tv[0]);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_idle("reset");

    // Chain test: reset-time carry_q must be 0.
    drive(tv[4]);
    chain = 1'b1;
    a0 = 4'h0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("chain0.mout1", {28'd0, mout1}, 32'd0);
    chk("chain0.cout",  {31'd0, cout},  32'd0);
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      drive(tv[i]);
      in_valid = 1'b1;
      chk($sformatf("v%0d.in_ready", i), {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("v%0d.lat", i), {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      chk_out($sformatf("v%0d", i), tv[i]);
      @(negedge clk);
    end

    // Back-pressure: two accepted, third stalls, then drain in order.
    out_ready = 1'b0;
    drive(tv[0]);
    in_valid = 1'b1;
    chk("bp.rdy1", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    drive(tv[1]);
    chk("bp.rdy2", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    drive(tv[2]);
    chk("bp.rdy3", {31'd0, in_ready}, 32'd0);
    chk_out("bp.hold0", tv[0]);
    @(negedge clk);
    chk("bp.rdy4", {31'd0, in_ready}, 32'd0);
    chk_out("bp.hold1", tv[0]);
    @(negedge clk);
    chk_out("bp.hold2", tv[0]);
    out_ready = 1'b1;
    #1;
    chk("bp.rdy5", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk_out("bp.out1", tv[1]);
    @(negedge clk);
    chk_out("bp.out2", tv[2]);
    @(negedge clk);
    chk("bp.drain", {31'd0, out_valid}, 32'd0);

    // Reset with both stages full and a competing accept.
    out_ready = 1'b0;
    drive(tv[3]);
    in_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst.full", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk_idle("rst.mid");
    out_ready = 1'b1;
    drive(tv[4]);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk_out("rst.chain", tv[6]);
    @(negedge clk);
    chk("rst.end", {31'd0, out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
